// File: rtl/dmem_initiator_pkg.sv
// dmem_pkg: shared types and access helpers for the data-memory initiator
package dmem_pkg;
    typedef enum logic [2:0] {MEM_B = 3'd0, MEM_H = 3'd1, MEM_W = 3'd2, MEM_BU = 3'd4, MEM_HU = 3'd5} dmem_funct3_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} dmem_state_t;
    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        fault;
    } dmem_rsp_t;

    function automatic logic is_fault(input logic store, input logic [2:0] f3, input logic [1:0] o);
        return (f3 == 3'd3) || (f3[2:1] == 2'b11) || (store && f3[2]) ||
               ((f3 == MEM_H || f3 == MEM_HU) && o[0]) || (f3 == MEM_W && o != 2'b00);
    endfunction

    function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] o);
        return f3[1:0] == 2'd0 ? 4'b0001 << o : f3[1:0] == 2'd1 ? 4'b0011 << o : 4'b1111;
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] rdata);
        logic [31:0] lane;
        lane = rdata >> {o, 3'b000};
        return f3 == MEM_B  ? {{24{lane[7]}}, lane[7:0]} :
               f3 == MEM_H  ? {{16{lane[15]}}, lane[15:0]} :
               f3 == MEM_BU ? {24'd0, lane[7:0]} :
               f3 == MEM_HU ? {16'd0, lane[15:0]} : lane;
    endfunction
endpackage

// File: rtl/dmem_initiator_if.sv
// dmem_initiator_if: request, response and memory-port signals of the initiator
interface dmem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_fault;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, rsp_ready, mem_rdata, mem_resp,
        output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_fault, mem_addr, mem_rmask, mem_wmask, mem_wdata
    );
    modport slave (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, rsp_ready, mem_rdata, mem_resp,
        input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_fault, mem_addr, mem_rmask, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/dmem_rsp_fifo2.sv
// dmem_rsp_fifo2: 2-entry response FIFO taking up to two ordered pushes and one pop per cycle
module dmem_rsp_fifo2 import dmem_pkg::*; (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_a,
    input  dmem_rsp_t din_a,
    input  logic      push_b,
    input  dmem_rsp_t din_b,
    input  logic      pop,
    output dmem_rsp_t head,
    output logic [1:0] count
);
    dmem_rsp_t q0, q1, n0, n1, s0;
    logic [1:0] c1, c2, count_next;

    // pop shifts first, then push_a lands ahead of push_b
    always_comb begin
        c1 = count - {1'b0, pop};
        c2 = c1 + {1'b0, push_a};
        s0 = pop ? q1 : q0;
        n0 = push_a && c1 == 2'd0 ? din_a : push_b && c2 == 2'd0 ? din_b : s0;
        n1 = push_a && c1 == 2'd1 ? din_a : push_b && c2 == 2'd1 ? din_b : q1;
        count_next = c2 + {1'b0, push_b};
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            q0 <= '0;
            q1 <= '0;
            count <= 2'd0;
        end else begin
            q0 <= n0;
            q1 <= n1;
            count <= count_next;
        end

    assign head = q0;
endmodule

// File: rtl/dmem_initiator.sv
// dmem_initiator: MEM-stage load/store initiator with masked word port and 2-entry response buffer
module dmem_initiator import dmem_pkg::*; (
    input logic clk,
    input logic rst_n,
    dmem_initiator_if.master bus
);
    dmem_state_t state, state_next;
    logic [1:0] cnt, cnt_next;
    logic bad, accept, acc_ok, mem_push, pop;
    logic [3:0] mask;
    logic cur_store;
    logic [2:0] cur_f3;
    logic [1:0] cur_off;
    logic [4:0] cur_rd;
    dmem_rsp_t mem_e, fault_e, head;

    // req_ready looks through this cycle's mem_resp and pop so the buffer never overflows
    always_comb begin
        bad = is_fault(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);
        mask = byte_mask(bus.req_funct3, bus.req_addr[1:0]);
        mem_push = state == WAIT && bus.mem_resp;
        pop = bus.rsp_valid && bus.rsp_ready;
        cnt_next = cnt + {1'b0, mem_push} - {1'b0, pop};
        bus.req_ready = (state == IDLE || mem_push) && cnt_next <= 2'd1;
        accept = bus.req_valid && bus.req_ready;
        acc_ok = accept && !bad;
        mem_e = '{data: cur_store ? 32'd0 : load_fmt(cur_f3, cur_off, bus.mem_rdata), rd: cur_rd, fault: 1'b0};
        fault_e = '{data: 32'd0, rd: bus.req_rd, fault: 1'b1};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = acc_ok ? ISSUE : IDLE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = bus.mem_resp ? (acc_ok ? ISSUE : IDLE) : WAIT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            bus.mem_addr <= 32'd0;
            bus.mem_wdata <= 32'd0;
            bus.mem_rmask <= 4'd0;
            bus.mem_wmask <= 4'd0;
            cur_store <= 1'b0;
            cur_f3 <= 3'd0;
            cur_off <= 2'd0;
            cur_rd <= 5'd0;
        end else begin
            state <= state_next;
            bus.mem_rmask <= acc_ok && !bus.req_store ? mask : 4'd0;
            bus.mem_wmask <= acc_ok && bus.req_store ? mask : 4'd0;
            if (acc_ok) begin
                bus.mem_addr <= {bus.req_addr[31:2], 2'b00};
                bus.mem_wdata <= bus.req_wdata << {bus.req_addr[1:0], 3'b000};
                cur_store <= bus.req_store;
                cur_f3 <= bus.req_funct3;
                cur_off <= bus.req_addr[1:0];
                cur_rd <= bus.req_rd;
            end
        end

    dmem_rsp_fifo2 u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push_a(mem_push),
        .din_a(mem_e),
        .push_b(accept && bad),
        .din_b(fault_e),
        .pop(pop),
        .head(head),
        .count(cnt)
    );

    assign bus.rsp_valid = cnt != 2'd0;
    assign bus.rsp_data = head.data;
    assign bus.rsp_rd = head.rd;
    assign bus.rsp_fault = head.fault;
endmodule

// File: tb/tb_dmem_initiator.sv
// tb_dmem_initiator: scoreboard bench with byte-level reference memory and a delayed word memory
module tb_dmem_initiator;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    dmem_initiator_if bus();
    dmem_initiator dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    dmem_rsp_t exp_q[$];
    dmem_rsp_t mon_e;
    logic [31:0] wmem[int];
    logic [7:0] bmem[int];
    logic rr_rand = 1'b0, rr_val = 1'b1, spur_en = 1'b0;
    int dly_min = 0, dly_max = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] rb(input int a);
        return bmem.exists(a) ? bmem[a] : 8'h00;
    endfunction

    task automatic init_word(input int a, input logic [31:0] v);
        wmem[a >> 2] = v;
        for (int i = 0; i < 4; i++) bmem[a + i] = v[8*i +: 8];
    endtask

    // reference: size from funct3, little-endian bytes, arithmetic sign extension
    function automatic void model_accept(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [4:0] rd);
        dmem_rsp_t e;
        int n = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        int a = int'(addr);
        longint v = 0;
        bit bad = f3 == 3'd3 || f3 >= 3'd6 || (store && f3 >= 3'd4) || (n == 2 && addr[0]) ||
                  (n == 4 && addr[1:0] != 2'd0);
        e.rd = rd;
        e.fault = bad;
        e.data = 32'd0;
        if (!bad) begin
            for (int i = 0; i < n; i++)
                if (store) bmem[a + i] = wdata[8*i +: 8];
                else v += longint'(rb(a + i)) << (8 * i);
            if (!store && f3 < 3'd2 && v >= (64'sd1 <<< (8 * n - 1))) v -= 64'sd1 <<< (8 * n);
            e.data = v[31:0];
        end
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) exp_q.delete();
        else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got %h with nothing expected",
                             {bus.rsp_data, bus.rsp_rd, bus.rsp_fault});
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp", 64'({bus.rsp_data, bus.rsp_rd, bus.rsp_fault}), 64'(mon_e));
                end
            end
            if (bus.req_valid && bus.req_ready)
                model_accept(bus.req_store, bus.req_funct3, bus.req_addr, bus.req_wdata, bus.req_rd);
        end
    end

    // word memory answering after a random stall; also pulses stray mem_resp while idle
    initial begin
        int cnt, w;
        bit pend;
        logic [31:0] rdq, cur;
        pend = 0;
        cnt = 0;
        rdq = 0;
        bus.mem_resp = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_resp = 1'b0;
            bus.mem_rdata = $urandom;
            if (!rst_n) pend = 0;
            else if (pend) begin
                if (cnt == 0) begin
                    bus.mem_resp = 1'b1;
                    bus.mem_rdata = rdq;
                    pend = 0;
                end else cnt--;
            end else if (bus.mem_rmask != 4'd0 || bus.mem_wmask != 4'd0) begin
                check("mem_addr_align", 64'(bus.mem_addr[1:0]), 64'd0);
                w = int'(bus.mem_addr >> 2);
                cur = wmem.exists(w) ? wmem[w] : 32'd0;
                for (int i = 0; i < 4; i++) if (bus.mem_wmask[i]) cur[8*i +: 8] = bus.mem_wdata[8*i +: 8];
                wmem[w] = cur;
                rdq = cur;
                pend = 1;
                cnt = $urandom_range(dly_max, dly_min);
            end else if (spur_en && $urandom_range(0, 3) == 0) bus.mem_resp = 1'b1;
        end
    end

    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_store = store;
        bus.req_funct3 = f3;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        bus.req_rd = rd;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: req_ready stayed 0 for %0d cycles", n);
        end
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rr_rand = 1'b0;
        rr_val = 1'b1;
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < 500) begin
            step();
            n++;
        end
        if (n == 500) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d responses still expected", exp_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_store = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0;
        bus.req_rd = 5'd0;
        for (int a = 'h100; a < 'h140; a += 4) init_word(a, $urandom);
        init_word('h100, 32'hDEADBEEF);
        init_word('h200, 32'h0);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_rsp_rd", 64'(bus.rsp_rd), 64'd0);
        check("rst_rsp_fault", 64'(bus.rsp_fault), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_rmask", 64'(bus.mem_rmask), 64'd0);
        check("rst_wmask", 64'(bus.mem_wmask), 64'd0);
        check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        step();
        rst_n = 1'b1;
        step();

        send(1'b0, 3'd2, 32'h100, 32'd0, 5'd1);
        @(negedge clk);
        check("lw_c1_rmask", 64'(bus.mem_rmask), 64'hF);
        check("lw_c1_addr", 64'(bus.mem_addr), 64'h100);
        check("lw_c1_wmask", 64'(bus.mem_wmask), 64'd0);
        step();
        @(negedge clk);
        check("lw_c2_rmask", 64'(bus.mem_rmask), 64'd0);
        check("lw_c2_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        step();
        @(negedge clk);
        check("lw_c3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("lw_c3_rsp_data", 64'(bus.rsp_data), 64'hDEADBEEF);
        check("lw_c3_rsp_fault", 64'(bus.rsp_fault), 64'd0);
        step();

        send(1'b0, 3'd0, 32'h103, 32'd0, 5'd2);
        send(1'b0, 3'd4, 32'h103, 32'd0, 5'd3);
        send(1'b0, 3'd1, 32'h102, 32'd0, 5'd4);
        send(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 5'd5);
        @(negedge clk);
        check("sh_wmask", 64'(bus.mem_wmask), 64'hC);
        check("sh_wdata", 64'(bus.mem_wdata), 64'hABCD0000);
        check("sh_addr", 64'(bus.mem_addr), 64'h200);
        check("sh_rmask", 64'(bus.mem_rmask), 64'd0);
        step();
        send(1'b0, 3'd2, 32'h200, 32'd0, 5'd6);
        drain();

        send(1'b0, 3'd2, 32'h101, 32'd0, 5'd7);
        @(negedge clk);
        check("flt_rmask", 64'(bus.mem_rmask), 64'd0);
        check("flt_wmask", 64'(bus.mem_wmask), 64'd0);
        check("flt_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("flt_rsp_fault", 64'(bus.rsp_fault), 64'd1);
        check("flt_rsp_rd", 64'(bus.rsp_rd), 64'd7);
        check("flt_rsp_data", 64'(bus.rsp_data), 64'd0);
        step();
        drain();

        rr_val = 1'b0;
        send(1'b0, 3'd2, 32'h100, 32'd0, 5'd8);
        send(1'b0, 3'd2, 32'h104, 32'd0, 5'd9);
        fork
            send(1'b0, 3'd2, 32'h108, 32'd0, 5'd10);
            begin
                repeat (6) @(negedge clk);
                check("full_req_ready", 64'(bus.req_ready), 64'd0);
                check("full_rsp_valid", 64'(bus.rsp_valid), 64'd1);
                step();
                rr_val = 1'b1;
            end
        join
        drain();

        send(1'b0, 3'd2, 32'h104, 32'd0, 5'd11);
        check("rst_issue_rmask_pre", 64'(bus.mem_rmask), 64'hF);
        #2 rst_n = 1'b0;
        #1 check("rst_issue_rmask_async", 64'(bus.mem_rmask), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        dly_min = 5;
        dly_max = 7;
        rr_val = 1'b0;
        step();
        send(1'b0, 3'd2, 32'h101, 32'd0, 5'd12);
        send(1'b0, 3'd2, 32'h108, 32'd0, 5'd13);
        step();
        step();
        check("rst_wait_rsp_valid_pre", 64'(bus.rsp_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_wait_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_wait_rsp_rd", 64'(bus.rsp_rd), 64'd0);
        check("rst_wait_rmask", 64'(bus.mem_rmask), 64'd0);
        check("rst_wait_wmask", 64'(bus.mem_wmask), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        rr_val = 1'b1;
        step();
        send(1'b0, 3'd2, 32'h100, 32'd0, 5'd14);
        drain();

        rr_rand = 1'b1;
        spur_en = 1'b1;
        dly_min = 0;
        dly_max = 3;
        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 2)) step();
            send(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 32'h100 + 32'($urandom_range(0, 63)),
                 $urandom, 5'($urandom_range(0, 31)));
        end
        spur_en = 1'b0;
        drain();
        @(negedge clk);
        check("end_rsp_valid", 64'(bus.rsp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
